// File: rtl/arbitro_rr4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The master side drives requests and the release strobe; the slave side
// (the arbiter) returns the grant vector and its status flags.
interface arbitro_rr4_if;
    logic [3:0] solicitud;
    logic       fin;
    logic [3:0] concesion;
    logic [1:0] indice;
    logic       ocupado;
    logic       expulsion;

    modport master (
        output solicitud,
        output fin,
        input  concesion,
        input  indice,
        input  ocupado,
        input  expulsion
    );

    modport slave (
        input  solicitud,
        input  fin,
        output concesion,
        output indice,
        output ocupado,
        output expulsion
    );
endinterface

// File: rtl/arbitro_rr4.sv
// Four-way round-robin arbiter with an explicit release handshake, a
// one-cycle dead gap between owners and optional timeout preemption.
// All outputs come straight from registers through a 2-to-4 decode, so no
// input ever reaches the grant vector combinationally.
module arbitro_rr4 #(
    parameter int TIEMPO_MAX = 15,
    parameter int ANCHO_CONT = 4
) (
    input  logic          reloj,
    input  logic          reset,
    arbitro_rr4_if.slave  bus
);

    typedef enum logic [1:0] {
        LIBRE     = 2'b00,
        CONCEDIDO = 2'b01,
        PAUSA     = 2'b10
    } estado_t;

    // Hold-counter value seen during the last permitted grant cycle; the
    // counter is 0 in the first grant cycle, so matching TIEMPO_MAX-1 means
    // the owner has held the resource for exactly TIEMPO_MAX cycles.
    localparam logic [ANCHO_CONT-1:0] LIMITE =
        ANCHO_CONT'((TIEMPO_MAX == 0) ? 0 : TIEMPO_MAX - 1);
    localparam logic EXPULSION_ACTIVA = (TIEMPO_MAX != 0);

    estado_t               estado,    estado_sig;
    logic [1:0]            indice,    indice_sig;
    logic [ANCHO_CONT-1:0] contador,  contador_sig;
    logic                  expulsion, expulsion_sig;

    logic [3:0] mascara_dueno;
    logic [2:0] ganador;
    logic       libera_fin;
    logic       libera_baja;
    logic       libera_tiempo;
    logic       libera;

    // One-hot decode of a 2-bit index.
    function automatic logic [3:0] decodifica(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Round-robin search: scan requests starting just after the last owner,
    // ascending with wrap. Bit 2 of the result flags that a winner exists,
    // bits 1:0 carry its index. The last owner is visited last, which gives
    // the released requester the lowest priority.
    function automatic logic [2:0] busca_ganador(input logic [3:0] sol,
                                                 input logic [1:0] ultimo);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            cand = ultimo + 2'(k);
            if (!res[2] && sol[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    // Saturating increment so a long-lived owner never wraps the counter
    // back into the preemption window.
    function automatic logic [ANCHO_CONT-1:0] incrementa_sat(
        input logic [ANCHO_CONT-1:0] valor);
        return (&valor) ? valor : valor + 1'b1;
    endfunction

    assign mascara_dueno = decodifica(indice);
    assign ganador       = busca_ganador(bus.solicitud, indice);

    // Release causes while granted: explicit Fin, owner withdrawing its
    // request, or timeout with at least one other requester waiting.
    assign libera_fin    = bus.fin;
    assign libera_baja   = ~|(bus.solicitud & mascara_dueno);
    assign libera_tiempo = EXPULSION_ACTIVA
                         && (contador == LIMITE)
                         && (|(bus.solicitud & ~mascara_dueno));
    assign libera        = libera_fin || libera_baja || libera_tiempo;

    // State register; reset parks the pointer at 3 so requester 0 is first.
    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            estado    <= LIBRE;
            indice    <= 2'b11;
            contador  <= '0;
            expulsion <= 1'b0;
        end else begin
            estado    <= estado_sig;
            indice    <= indice_sig;
            contador  <= contador_sig;
            expulsion <= expulsion_sig;
        end
    end

    // Next-state logic: arbitrate in LIBRE/PAUSA, hold or release in
    // CONCEDIDO. Expulsion is only raised for a pure timeout release.
    always_comb begin
        estado_sig    = estado;
        indice_sig    = indice;
        contador_sig  = contador;
        expulsion_sig = 1'b0;
        case (estado)
            LIBRE, PAUSA: begin
                if (ganador[2]) begin
                    indice_sig   = ganador[1:0];
                    contador_sig = '0;
                    estado_sig   = CONCEDIDO;
                end else begin
                    estado_sig   = LIBRE;
                end
            end
            CONCEDIDO: begin
                if (libera) begin
                    estado_sig    = PAUSA;
                    expulsion_sig = libera_tiempo && !libera_fin && !libera_baja;
                end else begin
                    contador_sig  = incrementa_sat(contador);
                end
            end
            default: begin
                estado_sig = LIBRE;
            end
        endcase
    end

    assign bus.ocupado   = (estado == CONCEDIDO);
    assign bus.concesion = bus.ocupado ? mascara_dueno : 4'b0000;
    assign bus.indice    = indice;
    assign bus.expulsion = expulsion;

endmodule

// File: tb/tb_arbitro_rr4.sv
// Directed bench for arbitro_rr4 built with TIEMPO_MAX=4: fair rotation,
// release gap, timeout preemption, owner withdrawal and asynchronous reset.
module tb_arbitro_rr4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    arbitro_rr4_if bus ();

    arbitro_rr4 #(
        .TIEMPO_MAX (4),
        .ANCHO_CONT (4)
    ) dut (
        .reloj (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] c,
                         input logic [1:0] i, input logic o, input logic e);
        checks++;
        assert ({bus.concesion, bus.indice, bus.ocupado, bus.expulsion} === {c, i, o, e})
        else begin
            errors++;
            $error("FAIL %s: observed conc=%b idx=%b ocu=%b exp=%b, expected conc=%b idx=%b ocu=%b exp=%b",
                   tag, bus.concesion, bus.indice, bus.ocupado, bus.expulsion, c, i, o, e);
        end
    endtask

    // Reset pulse placed between clock edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    logic [3:0] orden [5];

    initial begin
        bus.solicitud = 4'b0000;
        bus.fin       = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_state", 4'b0000, 2'b11, 1'b0, 1'b0);
        #1 rst = 1'b0;

        // Requests 0110: requester 1 first, then 2 after a one-cycle gap.
        bus.solicitud = 4'b0110;
        tick();
        check("t1_grant1", 4'b0010, 2'b01, 1'b1, 1'b0);
        tick();
        check("t1_hold1", 4'b0010, 2'b01, 1'b1, 1'b0);
        bus.fin = 1'b1;
        tick();
        check("t1_gap", 4'b0000, 2'b01, 1'b0, 1'b0);
        bus.fin = 1'b0;
        tick();
        check("t1_grant2", 4'b0100, 2'b10, 1'b1, 1'b0);

        // Owner 2 withdraws without Fin: plain release, no Expulsion.
        bus.solicitud = 4'b0000;
        tick();
        check("drop_pause", 4'b0000, 2'b10, 1'b0, 1'b0);
        tick();
        check("drop_idle", 4'b0000, 2'b10, 1'b0, 1'b0);

        // All four requesting with Fin pulsed on each grant.
        do_reset();
        orden = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.solicitud = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr_grant%0d", k), orden[k], 2'(k % 4), 1'b1, 1'b0);
            if (k < 4) begin
                bus.fin = 1'b1;
                tick();
                check($sformatf("rr_gap%0d", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0);
                bus.fin = 1'b0;
            end
        end

        // Timeout preemption: requester 0 held exactly 4 cycles.
        bus.solicitud = 4'b0000;
        do_reset();
        bus.solicitud = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("to_hold%0d", k), 4'b0001, 2'b00, 1'b1, 1'b0);
        end
        tick();
        check("to_pause_expulsion", 4'b0000, 2'b00, 1'b0, 1'b1);
        tick();
        check("to_next_owner", 4'b0010, 2'b01, 1'b1, 1'b0);

        // Lone requester past the timeout keeps the grant.
        bus.solicitud = 4'b0000;
        do_reset();
        bus.solicitud = 4'b0001;
        tick();
        check("solo_grant", 4'b0001, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("solo_hold%0d", k), 4'b0001, 2'b00, 1'b1, 1'b0);
        end

        // Fin coinciding with the timeout cycle counts as a normal release.
        bus.solicitud = 4'b0000;
        do_reset();
        bus.solicitud = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("fin_to_hold%0d", k), 4'b0001, 2'b00, 1'b1, 1'b0);
        end
        bus.fin = 1'b1;
        tick();
        check("fin_to_pause", 4'b0000, 2'b00, 1'b0, 1'b0);
        bus.fin = 1'b0;
        tick();
        check("fin_to_next", 4'b0010, 2'b01, 1'b1, 1'b0);

        // Asynchronous reset between edges while requester 1 owns the grant.
        #2 rst = 1'b1;
        #1;
        check("async_reset", 4'b0000, 2'b11, 1'b0, 1'b0);
        bus.solicitud = 4'b1001;
        #1 rst = 1'b0;
        tick();
        check("after_reset_grant", 4'b0001, 2'b00, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
